// File: rtl/wrap_saed32_dp_param.sv
// Parametrised dual-port RAM wrapper with post-reset zero fill, write-collision merge and address range checks.
// Optional macro WRAP_SAED32_BYPASS_EN: cross-port read-during-write returns the post-write word.
module wrap_saed32_dp_param #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 128,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [AW-1:0]    A0,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] WEM0,
   input  logic             WE0,
   input  logic             CE0,
   output logic [WIDTH-1:0] Q0,
   input  logic [AW-1:0]    A1,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] WEM1,
   input  logic             WE1,
   input  logic             CE1,
   output logic [WIDTH-1:0] Q1,
   output logic             READY,
   output logic             COLL,
   output logic             OOR
);

   // state | meaning
   // FILL  | zero-fill sweep of word[cnt], accesses ignored
   // RUN   | normal dual-port operation
   typedef enum logic {FILL, RUN} state_t;

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             act, in0, in1, v0, v1, w0, w1, r0, r1, coll, oor;
   logic [WIDTH-1:0] old0, old1, new0, new1, merged, wr0, rd0, rd1;

   assign act  = READY & ~RST;
   assign in0  = {1'b0, A0} < DEPTH_W;
   assign in1  = {1'b0, A1} < DEPTH_W;
   assign v0   = act & CE0 & in0;
   assign v1   = act & CE1 & in1;
   assign w0   = v0 & WE0;
   assign w1   = v1 & WE1;
   assign r0   = v0 & ~WE0;
   assign r1   = v1 & ~WE1;
   assign coll = w0 & w1 & (A0 == A1);
   assign oor  = act & ((CE0 & ~in0) | (CE1 & ~in1));

   assign old0   = mem[A0];
   assign old1   = mem[A1];
   assign new0   = (old0 & ~WEM0) | (D0 & WEM0);
   assign new1   = (old1 & ~WEM1) | (D1 & WEM1);
   // port 0 owns every bit it masks in; port 1 fills only the remaining masked bits
   assign merged = (old0 & ~(WEM0 | WEM1)) | (D0 & WEM0) | (D1 & WEM1 & ~WEM0);
   assign wr0    = coll ? merged : new0;

`ifdef WRAP_SAED32_BYPASS_EN
   assign rd0 = (w1 && (A1 == A0)) ? new1 : old0;
   assign rd1 = (w0 && (A0 == A1)) ? new0 : old1;
`else
   assign rd0 = old0;
   assign rd1 = old1;
`endif

   always_ff @(posedge CLK) begin
      if (!RST && state == FILL) begin
         mem[cnt] <= '0;
      end else begin
         if (w0)
            mem[A0] <= wr0;
         if (w1 && !coll)
            mem[A1] <= new1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= FILL;
         cnt   <= '0;
         READY <= 1'b0;
         COLL  <= 1'b0;
         OOR   <= 1'b0;
         Q0    <= '0;
         Q1    <= '0;
      end else begin
         COLL <= coll;
         OOR  <= oor;
         if (r0)
            Q0 <= rd0;
         if (r1)
            Q1 <= rd1;
         case (state)
            FILL: begin
               if (cnt == LAST) begin
                  state <= RUN;
                  READY <= 1'b1;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_wrap_saed32_dp_param.sv
// Bench for wrap_saed32_dp_param: a DEPTH=128 and a DEPTH=100 instance share stimulus and are
// checked against an array-based behavioural model of the memory.
module tb_wrap_saed32_dp_param;

`ifdef WRAP_SAED32_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] A0 = '0, A1 = '0;
   logic [3:0] D0 = '0, D1 = '0, WEM0 = '0, WEM1 = '0;
   logic       WE0 = 1'b0, WE1 = 1'b0, CE0 = 1'b0, CE1 = 1'b0;

   logic [3:0] q0_a, q1_a, q0_b, q1_b;
   logic       rdy_a, rdy_b, coll_a, coll_b, oor_a, oor_b;
   logic [10:0] obs [2];

   int nvec = 0;
   int nerr = 0;

   logic [3:0] mm [2][128];
   int         dep [2] = '{128, 100};
   logic [3:0] eq0 [2], eq1 [2];
   logic       ecoll [2], eoor [2];

   always #5 CLK = ~CLK;

   wrap_saed32_dp_param #(.WIDTH(4), .DEPTH(128)) u_a (
      .CLK(CLK), .RST(RST),
      .A0(A0), .D0(D0), .WEM0(WEM0), .WE0(WE0), .CE0(CE0), .Q0(q0_a),
      .A1(A1), .D1(D1), .WEM1(WEM1), .WE1(WE1), .CE1(CE1), .Q1(q1_a),
      .READY(rdy_a), .COLL(coll_a), .OOR(oor_a));

   wrap_saed32_dp_param #(.WIDTH(4), .DEPTH(100)) u_b (
      .CLK(CLK), .RST(RST),
      .A0(A0), .D0(D0), .WEM0(WEM0), .WE0(WE0), .CE0(CE0), .Q0(q0_b),
      .A1(A1), .D1(D1), .WEM1(WEM1), .WE1(WE1), .CE1(CE1), .Q1(q1_b),
      .READY(rdy_b), .COLL(coll_b), .OOR(oor_b));

   always_comb begin
      obs[0] = {rdy_a, coll_a, oor_a, q1_a, q0_a};
      obs[1] = {rdy_b, coll_b, oor_b, q1_b, q0_b};
   end

   function automatic logic [10:0] expv(int k);
      return {1'b1, ecoll[k], eoor[k], eq1[k], eq0[k]};
   endfunction

   function automatic logic [3:0] bitwrite(logic [3:0] old, logic [3:0] d, logic [3:0] m);
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = m[b] ? d[b] : old[b];
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 128; i++) mm[k][i] = 4'h0;
         eq0[k] = 4'h0; eq1[k] = 4'h0; ecoll[k] = 1'b0; eoor[k] = 1'b0;
      end
   endtask

   // one RUN-mode cycle of the memory, from the current port inputs
   task automatic model_step();
      bit ok0, ok1, wr0, wr1, same;
      logic [3:0] o0, o1, nw;
      for (int k = 0; k < 2; k++) begin
         ok0  = CE0 && (int'(A0) < dep[k]);
         ok1  = CE1 && (int'(A1) < dep[k]);
         wr0  = ok0 && WE0;
         wr1  = ok1 && WE1;
         same = (A0 == A1);
         o0   = mm[k][A0];
         o1   = mm[k][A1];
         if (wr0 && wr1 && same) begin
            for (int b = 0; b < 4; b++)
               nw[b] = WEM0[b] ? D0[b] : (WEM1[b] ? D1[b] : o0[b]);
            mm[k][A0] = nw;
         end else begin
            if (wr0) mm[k][A0] = bitwrite(o0, D0, WEM0);
            if (wr1) mm[k][A1] = bitwrite(o1, D1, WEM1);
         end
         if (ok0 && !WE0) eq0[k] = (BYP && wr1 && same) ? mm[k][A0] : o0;
         if (ok1 && !WE1) eq1[k] = (BYP && wr0 && same) ? mm[k][A1] : o1;
         ecoll[k] = wr0 && wr1 && same;
         eoor[k]  = (CE0 && int'(A0) >= dep[k]) || (CE1 && int'(A1) >= dep[k]);
      end
   endtask

   task automatic cyc(input bit c0, input bit w0, input logic [6:0] a0, input logic [3:0] d0,
                      input logic [3:0] m0, input bit c1, input bit w1, input logic [6:0] a1,
                      input logic [3:0] d1, input logic [3:0] m1);
      CE0 = c0; WE0 = w0; A0 = a0; D0 = d0; WEM0 = m0;
      CE1 = c1; WE1 = w1; A1 = a1; D1 = d1; WEM1 = m1;
      model_step();
      @(posedge CLK); #1;
   endtask

   task automatic idle_inputs();
      CE0 = 0; WE0 = 0; CE1 = 0; WE1 = 0; A0 = '0; A1 = '0;
      D0 = '0; D1 = '0; WEM0 = '0; WEM1 = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      nvec++;
      if (obs[0] !== 11'h0) begin nerr++; $display("FAIL reset_a got %h want 000", obs[0]); end
      nvec++;
      if (obs[1] !== 11'h0) begin nerr++; $display("FAIL reset_b got %h want 000", obs[1]); end
   endtask

   // RST must be high on entry; counts edges after it falls until each READY rises
   task automatic count_fill(input string tag);
      int n0, n1;
      n0 = -1; n1 = -1;
      RST = 1'b0;
      for (int n = 1; n <= 300 && (n0 < 0 || n1 < 0); n++) begin
         if (n < 100) begin
            CE0 = 1; WE0 = 1; A0 = 7'd0; D0 = 4'hF; WEM0 = 4'hF;
            CE1 = 1; WE1 = 0; A1 = 7'd120;
         end else begin
            idle_inputs();
         end
         @(posedge CLK); #1;
         if (n0 < 0 && rdy_a) n0 = n;
         if (n1 < 0 && rdy_b) n1 = n;
         if (n <= 100) begin
            nvec++;
            if ({coll_a, oor_a, q1_a, coll_b, oor_b, q1_b} !== 12'h0) begin
               nerr++;
               $display("FAIL %s_gated cyc %0d got %h want 000", tag, n,
                        {coll_a, oor_a, q1_a, coll_b, oor_b, q1_b});
            end
         end
      end
      nvec++;
      if (n0 !== 128) begin nerr++; $display("FAIL %s_ready_a got %0d want 128", tag, n0); end
      nvec++;
      if (n1 !== 100) begin nerr++; $display("FAIL %s_ready_b got %0d want 100", tag, n1); end
      idle_inputs();
      model_clear();
   endtask

   task automatic test_fill();
      count_fill("fill");
   endtask

   task automatic test_readall();
      for (int i = 0; i < 129; i++) begin
         cyc(i < 128, 0, 7'(i), 4'h0, 4'h0, i > 0, 0, 7'(128 - i), 4'h0, 4'h0);
         for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs[k] !== expv(k)) begin
               nerr++; $display("FAIL readall inst %0d addr %0d got %h want %h", k, i, obs[k], expv(k));
            end
         end
      end
   endtask

   task automatic test_mask();
      cyc(1, 1, 7'd5, 4'hF, 4'hF, 0, 0, 7'd0, 4'h0, 4'h0);
      cyc(1, 1, 7'd5, 4'h0, 4'b0101, 0, 0, 7'd0, 4'h0, 4'h0);
      cyc(0, 0, 7'd0, 4'h0, 4'h0, 1, 0, 7'd5, 4'h0, 4'h0);
      nvec++;
      if (q1_a !== 4'hA || q1_b !== 4'hA) begin
         nerr++; $display("FAIL mask got %h/%h want a/a", q1_a, q1_b);
      end
      for (int k = 0; k < 2; k++) begin
         nvec++;
         if (obs[k] !== expv(k)) begin nerr++; $display("FAIL mask_model inst %0d got %h want %h", k, obs[k], expv(k)); end
      end
   endtask

   task automatic test_collision();
      cyc(1, 1, 7'd9, 4'h3, 4'b0011, 1, 1, 7'd9, 4'hC, 4'hF);
      nvec++;
      if (coll_a !== 1'b1 || coll_b !== 1'b1) begin
         nerr++; $display("FAIL coll_pulse got %b%b want 11", coll_a, coll_b);
      end
      cyc(1, 0, 7'd9, 4'h0, 4'h0, 0, 0, 7'd0, 4'h0, 4'h0);
      nvec++;
      if ({coll_a, coll_b, q0_a, q0_b} !== {2'b00, 4'hF, 4'hF}) begin
         nerr++; $display("FAIL coll_word got %b%b %h %h want 00 f f", coll_a, coll_b, q0_a, q0_b);
      end
   endtask

   task automatic test_bypass();
      logic [3:0] want;
      want = BYP ? 4'h6 : 4'h1;
      cyc(1, 1, 7'd7, 4'h1, 4'hF, 0, 0, 7'd0, 4'h0, 4'h0);
      cyc(1, 1, 7'd7, 4'h6, 4'hF, 1, 0, 7'd7, 4'h0, 4'h0);
      nvec++;
      if (q1_a !== want || q1_b !== want) begin
         nerr++; $display("FAIL bypass got %h/%h want %h", q1_a, q1_b, want);
      end
      cyc(0, 0, 7'd0, 4'h0, 4'h0, 1, 0, 7'd7, 4'h0, 4'h0);
      nvec++;
      if (q1_a !== 4'h6 || q1_b !== 4'h6) begin
         nerr++; $display("FAIL bypass_after got %h/%h want 6", q1_a, q1_b);
      end
   endtask

   task automatic test_oor();
      cyc(1, 1, 7'd110, 4'hF, 4'hF, 0, 0, 7'd0, 4'h0, 4'h0);
      nvec++;
      if (oor_a !== 1'b0 || oor_b !== 1'b1) begin
         nerr++; $display("FAIL oor_write got %b%b want 01", oor_a, oor_b);
      end
      cyc(1, 1, 7'd110, 4'h5, 4'hF, 1, 1, 7'd110, 4'hA, 4'hF);
      nvec++;
      if ({coll_a, oor_a, coll_b, oor_b} !== 4'b1001) begin
         nerr++; $display("FAIL oor_coll got %b want 1001", {coll_a, oor_a, coll_b, oor_b});
      end
      cyc(0, 0, 7'd0, 4'h0, 4'h0, 1, 0, 7'd110, 4'h0, 4'h0);
      for (int k = 0; k < 2; k++) begin
         nvec++;
         if (obs[k] !== expv(k)) begin nerr++; $display("FAIL oor_read inst %0d got %h want %h", k, obs[k], expv(k)); end
      end
      cyc(0, 0, 7'd0, 4'h0, 4'h0, 0, 0, 7'd0, 4'h0, 4'h0);
      nvec++;
      if (oor_b !== 1'b0) begin nerr++; $display("FAIL oor_single got %b want 0", oor_b); end
   endtask

   task automatic test_random();
      logic [6:0] a0, a1;
      for (int i = 0; i < 600; i++) begin
         a0 = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
         a1 = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a0, 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a1, 4'($urandom), 4'($urandom));
         for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs[k] !== expv(k)) begin
               nerr++; $display("FAIL random inst %0d cyc %0d got %h want %h", k, i, obs[k], expv(k));
            end
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      idle_inputs();
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (50) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      nvec++;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
         nerr++; $display("FAIL midfill_reset got %b%b want 00", rdy_a, rdy_b);
      end
      count_fill("midfill");
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 7'(i * 13), 4'h0, 4'h0, 1, 0, 7'(i * 9 + 1), 4'h0, 4'h0);
         for (int k = 0; k < 2; k++) begin
            nvec++;
            if (obs[k] !== expv(k)) begin nerr++; $display("FAIL midfill_read inst %0d got %h want %h", k, obs[k], expv(k)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_readall();
      test_mask();
      test_collision();
      test_bypass();
      test_oor();
      test_random();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
